// File: rtl/lifo_cmd_seq.sv
// Command sequencer in front of an 11-bit LIFO: push/pop over valid/ready, one response per command.
// Optional LIFO_CMD_STATS_EN adds saturating overflow/underflow reject counters.
module lifo_cmd_seq #(
    parameter int unsigned DW    = 11,
    parameter int unsigned DEPTH = 15,
    parameter int unsigned CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          lifo_we,
    output logic          lifo_re,
    output logic [DW-1:0] lifo_din,
    input  logic [DW-1:0] lifo_dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
`ifdef LIFO_CMD_STATS_EN
    ,
    output logic [7:0]    ovf_cnt,
    output logic [7:0]    unf_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH   = 3'd1,
        POP    = 3'd2,
        POPCAP = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t state;

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            lifo_we   <= 1'b0;
            lifo_re   <= 1'b0;
            lifo_din  <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
`ifdef LIFO_CMD_STATS_EN
            ovf_cnt   <= '0;
            unf_cnt   <= '0;
`endif
        end else begin
            lifo_we <= 1'b0;
            lifo_re <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (!cmd_op) begin
                            if (full) begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_data  <= '0;
`ifdef LIFO_CMD_STATS_EN
                                if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
`endif
                            end else begin
                                state    <= PUSH;
                                lifo_we  <= 1'b1;
                                lifo_din <= cmd_data;
                                count    <= count + CW'(1);
                                full     <= (count == CW'(DEPTH - 1));
                                empty    <= 1'b0;
                            end
                        end else begin
                            if (empty) begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_data  <= '0;
`ifdef LIFO_CMD_STATS_EN
                                if (unf_cnt != 8'hFF) unf_cnt <= unf_cnt + 8'd1;
`endif
                            end else begin
                                state   <= POP;
                                lifo_re <= 1'b1;
                                count   <= count - CW'(1);
                                empty   <= (count == CW'(1));
                                full    <= 1'b0;
                            end
                        end
                    end
                end
                PUSH: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b0;
                end
                POP: begin
                    state <= POPCAP;
                end
                // LIFO address has settled after the decrement, so dout is the popped word.
                POPCAP: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= lifo_dout;
                    rsp_err   <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_cmd_seq.sv
// Self-checking bench for lifo_cmd_seq: directed cases plus random commands against a queue model.
module tb_lifo_cmd_seq;

    localparam int DW    = 11;
    localparam int DEPTH = 15;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          lifo_we;
    logic          lifo_re;
    logic [DW-1:0] lifo_din;
    logic [DW-1:0] lifo_dout;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
`ifdef LIFO_CMD_STATS_EN
    logic [7:0]    ovf_cnt;
    logic [7:0]    unf_cnt;
`endif

    always #5 clk = ~clk;

    lifo_cmd_seq #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .lifo_we   (lifo_we),
        .lifo_re   (lifo_re),
        .lifo_din  (lifo_din),
        .lifo_dout (lifo_dout),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef LIFO_CMD_STATS_EN
        ,
        .ovf_cnt   (ovf_cnt),
        .unf_cnt   (unf_cnt)
`endif
    );

    // Downstream LIFO stand-in: write at addr then increment, decrement on read, dout = mem[addr].
    logic [DW-1:0] lmem [0:15];
    logic [3:0]    laddr;
    always @(posedge clk) begin
        if (rst) begin
            laddr <= '0;
        end else if (lifo_we) begin
            lmem[laddr] <= lifo_din;
            if (laddr != 4'd15) laddr <= laddr + 4'd1;
        end else if (lifo_re) begin
            if (laddr != 4'd0) laddr <= laddr - 4'd1;
        end
    end
    assign lifo_dout = lmem[laddr];

    // Strobe monitor.
    int            we_cnt = 0;
    int            re_cnt = 0;
    int            both_cnt = 0;
    logic [DW-1:0] last_din = '0;
    always @(negedge clk) begin
        if (lifo_we) begin
            we_cnt   = we_cnt + 1;
            last_din = lifo_din;
        end
        if (lifo_re) re_cnt = re_cnt + 1;
        if (lifo_we && lifo_re) both_cnt = both_cnt + 1;
    end

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] model [$];
    int            exp_ovf = 0;
    int            exp_unf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_stats();
`ifdef LIFO_CMD_STATS_EN
        check("ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf));
        check("unf_cnt", 32'(unf_cnt), 32'(exp_unf));
`endif
    endtask

    // Issue one command, wait for its response, hold rsp_ready low for 'hold' cycles, then complete.
    task automatic do_cmd(input logic op, input logic [DW-1:0] data, input int hold);
        logic          exp_err;
        logic [DW-1:0] exp_data;
        int            exp_lat;
        int            lat;
        int            we0;
        int            re0;
        if (op == 1'b0) begin
            exp_err  = (model.size() == DEPTH);
            exp_data = '0;
            exp_lat  = exp_err ? 1 : 2;
            if (exp_err) begin
                if (exp_ovf < 255) exp_ovf = exp_ovf + 1;
            end else begin
                model.push_back(data);
            end
        end else begin
            exp_err = (model.size() == 0);
            exp_lat = exp_err ? 1 : 3;
            if (exp_err) begin
                exp_data = '0;
                if (exp_unf < 255) exp_unf = exp_unf + 1;
            end else begin
                exp_data = model.pop_back();
            end
        end
        we0 = we_cnt;
        re0 = re_cnt;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = DW'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat = lat + 1;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("count", 32'(count), 32'(model.size()));
        check("full", 32'(full), 32'(model.size() == DEPTH));
        check("empty", 32'(empty), 32'(model.size() == 0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", 32'(rsp_data), 32'(exp_data));
            check("hold_err", 32'(rsp_err), 32'(exp_err));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", 32'(rsp_valid), 32'd0);
        check("cmd_ready_back", 32'(cmd_ready), 32'd1);
        check("we_pulses", 32'(we_cnt - we0), 32'((op == 1'b0 && !exp_err) ? 1 : 0));
        check("re_pulses", 32'(re_cnt - re0), 32'((op == 1'b1 && !exp_err) ? 1 : 0));
        if (op == 1'b0 && !exp_err) check("lifo_din", 32'(last_din), 32'(data));
        check("both_strobes", 32'(both_cnt), 32'd0);
        check_stats();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model.delete();
        exp_ovf = 0;
        exp_unf = 0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        apply_reset();

        // Reset state held over idle cycles.
        for (int i = 0; i < 5; i++) begin
            check("idle_count", 32'(count), 32'd0);
            check("idle_empty", 32'(empty), 32'd1);
            check("idle_full", 32'(full), 32'd0);
            check("idle_ready", 32'(cmd_ready), 32'd1);
            check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            check("idle_rsp", 32'({rsp_err, rsp_data}), 32'd0);
            check("idle_strobes", 32'({lifo_we, lifo_re}), 32'd0);
            check("idle_din", 32'(lifo_din), 32'd0);
            @(negedge clk);
        end
        check_stats();

        // LIFO ordering.
        do_cmd(1'b0, 11'h123, 0);
        do_cmd(1'b0, 11'h456, 0);
        do_cmd(1'b1, 11'h000, 0);
        do_cmd(1'b1, 11'h000, 0);

        // Underflow.
        do_cmd(1'b1, 11'h7FF, 0);

        // Fill, overflow, drain.
        for (int i = 1; i <= DEPTH; i++) do_cmd(1'b0, DW'(i), 0);
        check("full_after_fill", 32'(full), 32'd1);
        do_cmd(1'b0, 11'h010, 0);
        for (int i = 0; i < DEPTH; i++) do_cmd(1'b1, 11'h000, 0);

        // Backpressure on pop response.
        do_cmd(1'b0, 11'h2A5, 0);
        do_cmd(1'b1, 11'h000, 4);

        // Reset during POP with three entries.
        for (int i = 0; i < 3; i++) do_cmd(1'b0, DW'($urandom), 0);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("in_pop_re", 32'(lifo_re), 32'd1);
        apply_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        do_cmd(1'b1, 11'h000, 0);

        // Random traffic.
        for (int n = 0; n < 120; n++) begin
            do_cmd(($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1, DW'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
